// File: rtl/energy_detect_win_if.sv
// Bundles the sample front-end strobes and the decision outputs of energy_detect_win.
// The master modport drives samples and the compare operands; the slave modport is the detector.
interface energy_detect_win_if #(
    parameter int DW    = 13,
    parameter int NW    = 12,
    parameter int TW    = 12,
    parameter int ACC_W = 32
);
    logic                    in_valid;
    logic signed [DW-1:0]    sig_in;
    logic                    flush;
    logic signed [NW-1:0]    nvar;
    logic signed [TW-1:0]    thres;
    logic                    standby;
    logic                    dec_valid;
    logic                    dec;
    logic        [ACC_W-1:0] energy;
    logic                    sat;
    logic                    occupied;

    modport master (
        output in_valid, sig_in, flush, nvar, thres,
        input  standby, dec_valid, dec, energy, sat, occupied
    );

    modport slave (
        input  in_valid, sig_in, flush, nvar, thres,
        output standby, dec_valid, dec, energy, sat, occupied
    );
endinterface

// File: rtl/energy_detect_win.sv
// Windowed energy detector: squares and accumulates samples, compares scaled energy with
// nvar*thres once per window, and filters the decisions into a hysteresis occupancy flag.
module energy_detect_win #(
    parameter int DW       = 13,
    parameter int NW       = 12,
    parameter int TW       = 12,
    parameter int LOG2_N   = 5,
    parameter int ACC_W    = 32,
    parameter int SCALE_SH = 5,
    parameter int HOLD     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    energy_detect_win_if.slave bus
);
    localparam int CNT_W  = LOG2_N + 1;
    localparam int SQ_W   = 2 * DW;
    localparam int SUM_W  = ((SQ_W > ACC_W) ? SQ_W : ACC_W) + 1;
    localparam int CMP_W  = ACC_W + SCALE_SH + 1;
    localparam int PROD_W = NW + TW;

    localparam logic [CNT_W-1:0] N_C       = {{(CNT_W-1){1'b0}}, 1'b1} << LOG2_N;
    localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ACC_MAX_C = {ACC_W{1'b1}};

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DECIDE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   count_r;
    logic [ACC_W-1:0]   acc_r;
    logic               sat_w_r;
    logic [SQ_W-1:0]    sq_r;
    logic               sq_valid_r;
    logic               standby_r;
    logic               dec_valid_r;
    logic               dec_r;
    logic [ACC_W-1:0]   energy_r;
    logic               sat_r;
    logic               occupied_r;
    logic [3:0]         hyst_cnt_r;

    logic               accept_s;
    logic               close_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic signed [SQ_W-1:0]   sig_ext_s;
    logic signed [SQ_W-1:0]   sq_s;
    logic [SUM_W-1:0]   sum_s;
    logic [ACC_W-1:0]   acc_add_s;
    logic               sat_add_s;
    logic signed [PROD_W-1:0] nvar_ext_s;
    logic signed [PROD_W-1:0] thres_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [CMP_W-1:0]  prod_cmp_s;
    logic signed [CMP_W-1:0]  energy_cmp_s;
    logic               dec_s;
    logic               occupied_nx_s;
    logic [3:0]         hyst_nx_s;

    // Sample acceptance and window-close detection
    always_comb begin
        accept_s    = bus.in_valid & standby_r;
        count_inc_s = count_r + CNT_ONE_C;
        close_s     = 1'b0;
        if (state_r == ST_ACC) begin
            if (accept_s && (count_inc_s == N_C)) begin
                close_s = 1'b1;
            end else if (bus.flush && (accept_s || (count_r != {CNT_W{1'b0}}))) begin
                close_s = 1'b1;
            end else begin
                close_s = 1'b0;
            end
        end else begin
            close_s = 1'b0;
        end
    end

    // Squarer and saturating accumulator update
    always_comb begin
        sig_ext_s = {{DW{bus.sig_in[DW-1]}}, bus.sig_in};
        sq_s      = sig_ext_s * sig_ext_s;
        sum_s     = {{(SUM_W-ACC_W){1'b0}}, acc_r} + {{(SUM_W-SQ_W){1'b0}}, sq_r};
        acc_add_s = ACC_MAX_C;
        sat_add_s = 1'b0;
        if (sum_s > {{(SUM_W-ACC_W){1'b0}}, ACC_MAX_C}) begin
            acc_add_s = ACC_MAX_C;
            sat_add_s = 1'b1;
        end else begin
            acc_add_s = sum_s[ACC_W-1:0];
            sat_add_s = 1'b0;
        end
    end

    // Signed compare: a negative nvar*thres always loses to the non-negative energy
    always_comb begin
        nvar_ext_s   = {{TW{bus.nvar[NW-1]}}, bus.nvar};
        thres_ext_s  = {{NW{bus.thres[TW-1]}}, bus.thres};
        prod_s       = nvar_ext_s * thres_ext_s;
        prod_cmp_s   = {{(CMP_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        energy_cmp_s = {1'b0, acc_r, {SCALE_SH{1'b0}}};
        dec_s        = (energy_cmp_s > prod_cmp_s);
    end

    // Hysteresis: HOLD consecutive disagreeing decisions flip the occupancy flag
    always_comb begin
        occupied_nx_s = occupied_r;
        hyst_nx_s     = 4'd0;
        if (dec_s == occupied_r) begin
            occupied_nx_s = occupied_r;
            hyst_nx_s     = 4'd0;
        end else if ((hyst_cnt_r + 4'd1) == 4'(HOLD)) begin
            occupied_nx_s = ~occupied_r;
            hyst_nx_s     = 4'd0;
        end else begin
            occupied_nx_s = occupied_r;
            hyst_nx_s     = hyst_cnt_r + 4'd1;
        end
    end

    // Window FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ACC;
            count_r     <= {CNT_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            sat_w_r     <= 1'b0;
            sq_r        <= {SQ_W{1'b0}};
            sq_valid_r  <= 1'b0;
            standby_r   <= 1'b1;
            dec_valid_r <= 1'b0;
            dec_r       <= 1'b0;
            energy_r    <= {ACC_W{1'b0}};
            sat_r       <= 1'b0;
            occupied_r  <= 1'b0;
            hyst_cnt_r  <= 4'd0;
        end else begin
            sq_valid_r  <= accept_s;
            dec_valid_r <= 1'b0;
            if (accept_s) begin
                sq_r <= sq_s;
            end
            if (sq_valid_r) begin
                acc_r   <= acc_add_s;
                sat_w_r <= sat_w_r | sat_add_s;
            end
            case (state_r)
                ST_ACC: begin
                    if (accept_s) begin
                        count_r <= count_inc_s;
                    end
                    if (close_s) begin
                        state_r   <= ST_DRAIN;
                        standby_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    dec_r       <= dec_s;
                    energy_r    <= acc_r;
                    sat_r       <= sat_w_r;
                    dec_valid_r <= 1'b1;
                    acc_r       <= {ACC_W{1'b0}};
                    count_r     <= {CNT_W{1'b0}};
                    sat_w_r     <= 1'b0;
                    occupied_r  <= occupied_nx_s;
                    hyst_cnt_r  <= hyst_nx_s;
                    state_r     <= ST_ACC;
                    standby_r   <= 1'b1;
                end
                default: begin
                    state_r   <= ST_ACC;
                    standby_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.standby   = standby_r;
    assign bus.dec_valid = dec_valid_r;
    assign bus.dec       = dec_r;
    assign bus.energy    = energy_r;
    assign bus.sat       = sat_r;
    assign bus.occupied  = occupied_r;
endmodule
